ring_osc_trim_cal: RTL and testbench
====================================

Name: ring_osc_trim_cal

Overview:
Parametrised trim controller for the N-stage, two-trim-bit-per-stage ring oscillator. It converts a linear trim level into the non-binary primary/secondary trim word, or closes a frequency loop: it counts synchronised oscillator ticks over a fixed window of clk cycles and steps the level until the count is within tolerance of a target. It sits in the clocking block between the housekeeping registers and the oscillator's trim/reset pins.

Parameters:
NSTAGES, 13, number of oscillator stages; trim word is 2*NSTAGES bits.
LVL_W, $clog2(2*NSTAGES+1), width of the trim level (0..2*NSTAGES).
CNT_W, 16, tick-counter and target width.
WINDOW, 1024, measurement window length in clk cycles (>=2).
SETTLE, 16, clk cycles waited after every trim change before measuring.
LOCK_N, 3, consecutive in-band windows required to declare lock.

Ports:
clk  in  1  reference clock
resetb  in  1  asynchronous active-low reset
enable  in  1  1 = run; 0 = idle, oscillator held in reset
auto_mode  in  1  1 = closed-loop calibration; 0 = manual level
manual_level  in  LVL_W  level applied in manual mode (clamped to 2*NSTAGES)
target  in  CNT_W  required tick count per window
tol  in  CNT_W  allowed +/- deviation from target
osc_tick  in  1  single-cycle pulse per divided oscillator edge, already synchronised to clk
osc_reset  out  1  drives oscillator start-stage reset
trim  out  2*NSTAGES  {secondary[NSTAGES-1:0], primary[NSTAGES-1:0]}
level  out  LVL_W  current trim level
busy  out  1  calibration in progress (auto mode, not locked)
locked  out  1  LOCK_N consecutive windows in band
sat_hi  out  1  level at 2*NSTAGES and still too fast
sat_lo  out  1  level at 0 and still too slow

Behaviour:
- Reset: all outputs 0 except osc_reset=1; FSM IDLE; counters 0.
- Level decode (combinational from the level register): level k<=NSTAGES -> primary[k-1:0]=1, secondary=0; level NSTAGES+j -> primary all 1, secondary[j-1:0]=1. Higher level means a slower oscillator.
- States:
  - IDLE: osc_reset=1, trim/level hold. enable=1 -> SETTLE next cycle, with osc_reset=0.
  - SETTLE: count SETTLE cycles, then MEASURE.
  - MEASURE: window counter runs WINDOW cycles; the tick counter increments on osc_tick and saturates at all-ones. After the last window cycle -> EVAL.
  - EVAL (1 cycle): compare cnt against target, using CNT_W+1-bit arithmetic with no wrap.
    - cnt > target+tol -> level+1 (if level=2*NSTAGES: sat_hi=1, no change).
    - cnt < target-tol, with target-tol floored at 0 -> level-1 (if level=0: sat_lo=1, no change).
    - Otherwise in band: inband_cnt+1, and sat flags clear.
    - Any step clears inband_cnt and locked.
    - inband_cnt reaching LOCK_N -> locked=1.
    - Next state: SETTLE if level changed, else MEASURE.
  - LOCKED tracking: measuring continues while locked. A single out-of-band window drops locked and steps the level.
- Manual mode: level tracks the clamped manual_level every cycle; no measurement; busy=locked=sat=0. FSM cycles IDLE/RUN on enable only.
- busy = enable & auto_mode & ~locked.
- osc_tick outside MEASURE is ignored.
- Counters clear on entry to MEASURE.
- Events:
  - enable falling in any state -> IDLE next cycle; locked/busy/sat clear; level holds.
  - auto_mode toggled while running -> restart at SETTLE; inband_cnt cleared.
  - target/tol changes take effect at the next EVAL.
- Latency from a level change to trim change: 1 cycle (registered level, combinational decode).

Decomposition:
- Package ring_osc_pkg: FSM state enum; function lvl2trim(level, NSTAGES); max-level constant.
- Sub-module ring_osc_trim_decode (level -> trim word), reusable by the manual-only path elsewhere.

Test Plan:
- Reset/manual: resetb low -> trim=0, osc_reset=1. Release, enable=1, auto=0, manual_level=15 (NSTAGES=13) -> trim primary=0x1FFF, secondary=0x0003, osc_reset=0 next cycle.
- Clamp: manual_level=31 -> level=26, trim all ones.
- Auto converge: bench model tick count = 400-10*level per window; target=300, tol=5. Level steps every WINDOW+SETTLE+1 cycles, reaching 10. locked=1 after 3 in-band windows; busy falls with locked.
- Saturation: model count fixed at 500, target=100 -> level climbs to 26, then sat_hi=1 with level stable. Count 0 -> level 0, sat_lo=1.
- Lock loss: after lock, the model shifts by +50 -> locked drops at the next EVAL and the level increments.
- Mid-run disable: deassert enable during MEASURE -> IDLE next cycle, osc_reset=1, level held, busy=0. Re-enable -> SETTLE, then a fresh window with counters at 0.

Source files
------------

// File: rtl/ring_osc_pkg.sv
// Shared types and helpers for the ring-oscillator trim controller:
// FSM state encoding, maximum trim level and the level-to-trim-word decode.
package ring_osc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_RUN
  } state_t;

  // Widest trim word the decode helper can return (supports up to 32 stages).
  localparam int TRIM_MAX_W = 64;

  // Highest linear trim level for an oscillator with nstages stages.
  function automatic int max_level(input int nstages);
    return 2 * nstages;
  endfunction

  // Thermometer-style decode: the first nstages levels fill the primary
  // bits, the remaining levels fill the secondary bits. The result is
  // {secondary, primary} right-aligned in a TRIM_MAX_W-bit word.
  function automatic logic [TRIM_MAX_W-1:0] lvl2trim(input int level, input int nstages);
    int n_prim;
    int n_sec;
    logic [TRIM_MAX_W-1:0] ones;
    ones   = '1;
    n_prim = (level > nstages) ? nstages : level;
    n_sec  = (level > nstages) ? level - nstages : 0;
    if (n_sec > nstages) n_sec = nstages;
    return ~(ones << n_prim) | (~(ones << n_sec) << nstages);
  endfunction

endpackage

// File: rtl/ring_osc_trim_decode.sv
// Level -> trim word decode for the ring oscillator. Purely combinational,
// so the trim pins follow the registered level with no extra latency.
module ring_osc_trim_decode
  import ring_osc_pkg::*;
#(
  parameter int NSTAGES = 13,
  parameter int LVL_W   = $clog2(2*NSTAGES+1)
) (
  input  logic [LVL_W-1:0]     level,
  output logic [2*NSTAGES-1:0] trim
);

  localparam int TRIM_W = 2 * NSTAGES;

  // Map the linear level onto {secondary, primary} trim bits.
  always_comb begin
    trim = TRIM_W'(lvl2trim(int'(level), NSTAGES));
  end

endmodule

// File: rtl/ring_osc_trim_cal.sv
// Ring-oscillator trim controller. Manual mode applies a clamped level
// directly; auto mode settles, counts oscillator ticks over a fixed window
// and steps the level until the count sits inside target +/- tol.
module ring_osc_trim_cal
  import ring_osc_pkg::*;
#(
  parameter int NSTAGES = 13,
  parameter int LVL_W   = $clog2(2*NSTAGES+1),
  parameter int CNT_W   = 16,
  parameter int WINDOW  = 1024,
  parameter int SETTLE  = 16,
  parameter int LOCK_N  = 3
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 enable,
  input  logic                 auto_mode,
  input  logic [LVL_W-1:0]     manual_level,
  input  logic [CNT_W-1:0]     target,
  input  logic [CNT_W-1:0]     tol,
  input  logic                 osc_tick,
  output logic                 osc_reset,
  output logic [2*NSTAGES-1:0] trim,
  output logic [LVL_W-1:0]     level,
  output logic                 busy,
  output logic                 locked,
  output logic                 sat_hi,
  output logic                 sat_lo
);

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int IB_W  = $clog2(LOCK_N + 1);

  localparam logic [LVL_W-1:0] MAX_LVL     = LVL_W'(max_level(NSTAGES));
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW - 1);
  localparam logic [IB_W-1:0]  LOCK_CNT    = IB_W'(LOCK_N);

  state_t             state_reg;
  state_t             state_next;
  logic [LVL_W-1:0]   level_reg;
  logic [SET_W-1:0]   settle_cnt_reg;
  logic [WIN_W-1:0]   win_cnt_reg;
  logic [CNT_W-1:0]   tick_cnt_reg;
  logic [IB_W-1:0]    inband_reg;
  logic               locked_reg;
  logic               sat_hi_reg;
  logic               sat_lo_reg;
  logic               auto_reg;

  logic               auto_toggle;
  logic [LVL_W-1:0]   manual_clamped;
  logic [CNT_W:0]     cnt_x;
  logic [CNT_W:0]     band_hi;
  logic [CNT_W:0]     band_lo;
  logic               too_fast;
  logic               too_slow;
  logic               step_up;
  logic               step_dn;

  // A mode change only restarts the loop once the oscillator is running.
  assign auto_toggle    = (auto_mode != auto_reg) && (state_reg != ST_IDLE);
  assign manual_clamped = (manual_level > MAX_LVL) ? MAX_LVL : manual_level;

  // Band edges in one extra bit so target+tol cannot wrap; lower edge floors at 0.
  assign cnt_x    = {1'b0, tick_cnt_reg};
  assign band_hi  = {1'b0, target} + {1'b0, tol};
  assign band_lo  = (tol > target) ? '0 : ({1'b0, target} - {1'b0, tol});
  assign too_fast = cnt_x > band_hi;
  assign too_slow = cnt_x < band_lo;
  assign step_up  = too_fast && (level_reg != MAX_LVL);
  assign step_dn  = too_slow && (level_reg != '0);

  // State register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state: disable wins, then mode change, then the settle/measure/eval loop.
  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = ST_IDLE;
    end else if (auto_toggle) begin
      state_next = auto_mode ? ST_SETTLE : ST_RUN;
    end else begin
      case (state_reg)
        ST_IDLE:    state_next = auto_mode ? ST_SETTLE : ST_RUN;
        ST_SETTLE:  if (settle_cnt_reg == SETTLE_LAST) state_next = ST_MEASURE;
        ST_MEASURE: if (win_cnt_reg == WIN_LAST) state_next = ST_EVAL;
        ST_EVAL:    state_next = (step_up || step_dn) ? ST_SETTLE : ST_MEASURE;
        ST_RUN:     state_next = ST_RUN;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs: oscillator held in reset while idle; status only meaningful in auto mode.
  always_comb begin
    osc_reset = (state_reg == ST_IDLE);
    level     = level_reg;
    busy      = (state_reg != ST_IDLE) && enable && auto_mode && !locked_reg;
    locked    = locked_reg && auto_mode;
    sat_hi    = sat_hi_reg && auto_mode;
    sat_lo    = sat_lo_reg && auto_mode;
  end

  // Settle/window/tick counters; the tick count is cleared on entry to MEASURE
  // and held through EVAL so the comparison sees the full window.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      settle_cnt_reg <= '0;
      win_cnt_reg    <= '0;
      tick_cnt_reg   <= '0;
    end else begin
      settle_cnt_reg <= (state_reg == ST_SETTLE && state_next == ST_SETTLE)
                        ? settle_cnt_reg + SET_W'(1) : '0;
      win_cnt_reg    <= (state_reg == ST_MEASURE && state_next == ST_MEASURE)
                        ? win_cnt_reg + WIN_W'(1) : '0;
      if (state_reg != ST_MEASURE && state_next == ST_MEASURE)
        tick_cnt_reg <= '0;
      else if (state_reg == ST_MEASURE && osc_tick && tick_cnt_reg != '1)
        tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
    end
  end

  // Level, lock and saturation tracking.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      level_reg  <= '0;
      inband_reg <= '0;
      locked_reg <= 1'b0;
      sat_hi_reg <= 1'b0;
      sat_lo_reg <= 1'b0;
      auto_reg   <= 1'b0;
    end else begin
      auto_reg <= auto_mode;
      if (!enable || !auto_mode || auto_toggle) begin
        inband_reg <= '0;
        locked_reg <= 1'b0;
        sat_hi_reg <= 1'b0;
        sat_lo_reg <= 1'b0;
        if (enable && !auto_mode) level_reg <= manual_clamped;
      end else if (state_reg == ST_EVAL) begin
        if (too_fast || too_slow) begin
          inband_reg <= '0;
          locked_reg <= 1'b0;
          sat_hi_reg <= too_fast && !step_up;
          sat_lo_reg <= too_slow && !step_dn;
          if (step_up) level_reg <= level_reg + LVL_W'(1);
          if (step_dn) level_reg <= level_reg - LVL_W'(1);
        end else begin
          sat_hi_reg <= 1'b0;
          sat_lo_reg <= 1'b0;
          if (inband_reg != LOCK_CNT) inband_reg <= inband_reg + IB_W'(1);
          if (inband_reg >= LOCK_CNT - IB_W'(1)) locked_reg <= 1'b1;
        end
      end
    end
  end

  ring_osc_trim_decode #(
    .NSTAGES (NSTAGES),
    .LVL_W   (LVL_W)
  ) u_decode (
    .level (level_reg),
    .trim  (trim)
  );

endmodule

// File: tb/tb_ring_osc_trim_cal.sv
// Directed bench for ring_osc_trim_cal: manual decode/clamp, closed-loop
// convergence and lock timing, lock loss, saturation and mid-run disable.
module tb_ring_osc_trim_cal;

  localparam int NSTAGES  = 13;
  localparam int LVL_W    = 5;
  localparam int CNT_W    = 16;
  localparam int WINDOW   = 512;
  localparam int SETTLE   = 16;
  localparam int LOCK_N   = 3;
  localparam int STEP_CYC = SETTLE + WINDOW + 1;

  logic                 clk = 1'b0;
  logic                 resetb = 1'b0;
  logic                 enable = 1'b0;
  logic                 auto_mode = 1'b0;
  logic [LVL_W-1:0]     manual_level = '0;
  logic [CNT_W-1:0]     target = '0;
  logic [CNT_W-1:0]     tol = '0;
  logic                 osc_tick = 1'b0;
  logic                 osc_reset;
  logic [2*NSTAGES-1:0] trim;
  logic [LVL_W-1:0]     level;
  logic                 busy;
  logic                 locked;
  logic                 sat_hi;
  logic                 sat_lo;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Oscillator model: rate = ticks per WINDOW cycles
  bit fixed_en = 1'b0;
  int fixed_val = 0;
  int offset = 0;
  int acc = 0;

  ring_osc_trim_cal #(
    .NSTAGES (NSTAGES),
    .LVL_W   (LVL_W),
    .CNT_W   (CNT_W),
    .WINDOW  (WINDOW),
    .SETTLE  (SETTLE),
    .LOCK_N  (LOCK_N)
  ) dut (
    .clk          (clk),
    .resetb       (resetb),
    .enable       (enable),
    .auto_mode    (auto_mode),
    .manual_level (manual_level),
    .target       (target),
    .tol          (tol),
    .osc_tick     (osc_tick),
    .osc_reset    (osc_reset),
    .trim         (trim),
    .level        (level),
    .busy         (busy),
    .locked       (locked),
    .sat_hi       (sat_hi),
    .sat_lo       (sat_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Evenly spread ticks: exactly 'rate' pulses in any WINDOW-cycle span of constant rate
  always @(negedge clk) begin
    int rate;
    rate = fixed_en ? fixed_val : (400 - 10 * int'(level) + offset);
    acc = acc + rate;
    if (acc >= WINDOW) begin
      osc_tick = 1'b1;
      acc = acc - WINDOW;
    end else begin
      osc_tick = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=0x%0h", tag, got);
    end
  endtask

  task automatic wait_change(input int budget, output int at_cyc, output bit seen);
    logic [LVL_W-1:0] prev;
    prev   = level;
    seen   = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (level != prev) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_prev;
    int t_now;
    int t10;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_trim", trim, 0);
    check_eq("rst_osc_reset", osc_reset, 1);
    check_eq("rst_level", level, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_sat", {sat_hi, sat_lo}, 0);

    // Manual level 15 -> primary 0x1FFF, secondary 0x0003
    resetb = 1'b1;
    @(negedge clk);
    enable = 1'b1; auto_mode = 1'b0; manual_level = 5'd15;
    @(negedge clk);
    check_eq("man_trim", trim, 32'h0000_7FFF);
    check_eq("man_osc_reset", osc_reset, 0);
    check_eq("man_level", level, 15);
    check_eq("man_busy", busy, 0);

    // Clamp 31 -> 26, all ones
    manual_level = 5'd31;
    @(negedge clk);
    check_eq("clamp_level", level, 26);
    check_eq("clamp_trim", trim, 32'h03FF_FFFF);

    manual_level = 5'd0;
    @(negedge clk);
    check_eq("man0_trim", trim, 0);

    // Auto convergence: count = 400 - 10*level, band 295..305 -> level 10
    target = 16'd300; tol = 16'd5; auto_mode = 1'b1;
    t_prev = cyc;
    @(negedge clk);
    check_eq("auto_busy", busy, 1);
    for (int k = 1; k <= 10; k++) begin
      wait_change(STEP_CYC + 50, t_now, seen);
      check_eq("conv_seen", seen, 1);
      check_eq("conv_level", level, k);
      check_eq("conv_period", t_now - t_prev, (k == 1) ? STEP_CYC + 1 : STEP_CYC);
      t_prev = t_now;
    end

    // Lock after three in-band windows
    t10 = t_prev;
    for (int i = 0; i < 3 * WINDOW + SETTLE + 100 && !locked; i++) @(negedge clk);
    check_eq("lock_seen", locked, 1);
    check_eq("lock_time", cyc - t10, STEP_CYC + 2 * (WINDOW + 1));
    check_eq("lock_level", level, 10);
    check_eq("lock_busy", busy, 0);

    // Lock loss: +50 ticks -> out of band, step up
    offset = 50;
    for (int i = 0; i < 2 * (WINDOW + 1) + 10 && locked; i++) @(negedge clk);
    check_eq("loss_locked", locked, 0);
    check_eq("loss_level", level, 11);
    check_eq("loss_busy", busy, 1);

    // Saturation high: fixed 500 vs target 100
    fixed_en = 1'b1; fixed_val = 500; target = 16'd100;
    for (int i = 0; i < 20000 && !sat_hi; i++) @(negedge clk);
    check_eq("sathi_flag", sat_hi, 1);
    check_eq("sathi_level", level, 26);
    check_eq("sathi_trim", trim, 32'h03FF_FFFF);
    repeat (WINDOW + 10) @(negedge clk);
    check_eq("sathi_hold_level", level, 26);
    check_eq("sathi_hold_flag", sat_hi, 1);

    // Saturation low: no ticks at all
    fixed_val = 0;
    for (int i = 0; i < 18000 && !sat_lo; i++) @(negedge clk);
    check_eq("satlo_flag", sat_lo, 1);
    check_eq("satlo_level", level, 0);
    check_eq("satlo_sathi", sat_hi, 0);
    check_eq("satlo_trim", trim, 0);

    // Mid-run disable during MEASURE
    fixed_en = 1'b0; offset = 0; target = 16'd300;
    wait_change(2 * STEP_CYC, t_now, seen);
    check_eq("dis_pre_level", level, 1);
    repeat (SETTLE + 100) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_eq("dis_osc_reset", osc_reset, 1);
    check_eq("dis_level", level, 1);
    check_eq("dis_busy", busy, 0);
    check_eq("dis_locked", locked, 0);
    check_eq("dis_trim", trim, 1);
    repeat (50) @(negedge clk);
    check_eq("dis_hold_level", level, 1);

    // Re-enable: settle plus a full fresh window before the next step
    enable = 1'b1;
    t_prev = cyc;
    @(negedge clk);
    check_eq("reen_osc_reset", osc_reset, 0);
    wait_change(STEP_CYC + 50, t_now, seen);
    check_eq("reen_seen", seen, 1);
    check_eq("reen_level", level, 2);
    check_eq("reen_period", t_now - t_prev, STEP_CYC + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
